// File: rtl/nonce_sequencer_pkg.sv
// Shared definitions for the nonce sequencer: FSM state encoding and default
// sizing that the hash core and comparator also build against.
package nonce_sequencer_pkg;

  localparam int NONCE_W_DEF     = 32;
  localparam int PIPE_LAT_DEF    = 4;
  localparam int TIMEOUT_CYC_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic is_busy(state_t s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/nonce_sequencer_if.sv
// Control/status bundle between the search controller (master) and the
// nonce sequencer (slave).
interface nonce_sequencer_if
  import nonce_sequencer_pkg::*;
#(
  parameter int NONCE_W = NONCE_W_DEF
);
  logic               start;
  logic [NONCE_W-1:0] nonce_start;
  logic [NONCE_W-1:0] nonce_limit;
  logic               valid_in;
  logic [NONCE_W-1:0] nonce_1;
  logic               nonce_vld;
  logic               fin;
  logic               busy;
  logic               found;
  logic               exhausted;
  logic               timed_out;

  modport master (
    output start, nonce_start, nonce_limit, valid_in,
    input  nonce_1, nonce_vld, fin, busy, found, exhausted, timed_out
  );

  modport slave (
    input  start, nonce_start, nonce_limit, valid_in,
    output nonce_1, nonce_vld, fin, busy, found, exhausted, timed_out
  );
endinterface

// File: rtl/nonce_sequencer.sv
// Issues one candidate nonce per cycle to the hash core and freezes the comparator
// (fin) on a hit or range exhaustion. Optional cycle budget: NONCE_SEQ_TIMEOUT_EN.
module nonce_sequencer
  import nonce_sequencer_pkg::*;
#(
  parameter int NONCE_W     = NONCE_W_DEF,
  parameter int PIPE_LAT    = PIPE_LAT_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic              clk,
  input logic              reset,
  nonce_sequencer_if.slave bus
);

  localparam int DW = $clog2(PIPE_LAT + 1);

  state_t             state, state_nxt;
  logic [NONCE_W-1:0] nonce_q;
  logic [NONCE_W-1:0] limit_q;
  logic               nonce_vld_q;
  logic [DW-1:0]      drain_cnt;
  logic               found_q;
  logic               exhausted_q;
  logic               launch;
  logic               at_limit;
  logic               budget_hit;

  assign launch   = !is_busy(state) && bus.start;
  assign at_limit = (nonce_q == limit_q);

`ifdef NONCE_SEQ_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] cyc_cnt;
  logic          to_pend;
  logic          timed_out_q;

  assign budget_hit = (cyc_cnt == CW'(TIMEOUT_CYC - 1));
`else
  logic unused_cfg;

  assign unused_cfg = (TIMEOUT_CYC != 0);
  assign budget_hit = 1'b0;
`endif

  always_comb begin : next_state
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE: if (bus.start) state_nxt = ST_RUN;
      ST_RUN: begin
        if (bus.valid_in)               state_nxt = ST_DONE;
        else if (at_limit || budget_hit) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (bus.valid_in || drain_cnt == DW'(1)) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The limit only matters while searching, so it is loaded on launch and never reset.
  always_ff @(posedge clk) begin
    if (launch) limit_q <= bus.nonce_limit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      nonce_q     <= '0;
      nonce_vld_q <= 1'b0;
      drain_cnt   <= '0;
      found_q     <= 1'b0;
      exhausted_q <= 1'b0;
`ifdef NONCE_SEQ_TIMEOUT_EN
      cyc_cnt     <= '0;
      to_pend     <= 1'b0;
      timed_out_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            nonce_q     <= bus.nonce_start;
            nonce_vld_q <= 1'b1;
            found_q     <= 1'b0;
            exhausted_q <= 1'b0;
`ifdef NONCE_SEQ_TIMEOUT_EN
            cyc_cnt     <= '0;
            to_pend     <= 1'b0;
            timed_out_q <= 1'b0;
`endif
          end
        end
        ST_RUN: begin
          if (bus.valid_in) begin
            nonce_vld_q <= 1'b0;
            found_q     <= 1'b1;
          end else if (at_limit || budget_hit) begin
            // Hold the last nonce; the drain window covers its result in flight.
            nonce_vld_q <= 1'b0;
            drain_cnt   <= DW'(PIPE_LAT);
`ifdef NONCE_SEQ_TIMEOUT_EN
            to_pend     <= !at_limit;
`endif
          end else begin
            nonce_q <= nonce_q + NONCE_W'(1);
`ifdef NONCE_SEQ_TIMEOUT_EN
            cyc_cnt <= cyc_cnt + CW'(1);
`endif
          end
        end
        ST_DRAIN: begin
          if (bus.valid_in) begin
            found_q <= 1'b1;
          end else if (drain_cnt == DW'(1)) begin
            drain_cnt <= '0;
`ifdef NONCE_SEQ_TIMEOUT_EN
            if (to_pend) timed_out_q <= 1'b1;
            else         exhausted_q <= 1'b1;
`else
            exhausted_q <= 1'b1;
`endif
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin : outputs
    bus.nonce_1   = nonce_q;
    bus.nonce_vld = nonce_vld_q;
    bus.busy      = is_busy(state);
    bus.fin       = !is_busy(state);
    bus.found     = found_q;
    bus.exhausted = exhausted_q;
`ifdef NONCE_SEQ_TIMEOUT_EN
    bus.timed_out = timed_out_q;
`else
    bus.timed_out = 1'b0;
`endif
  end

endmodule

// File: tb/tb_nonce_sequencer.sv
// Scoreboard bench for nonce_sequencer: a hash-core delay model raises valid_in on a
// chosen target nonce; expected nonce streams and final flags come from range arithmetic.
module tb_nonce_sequencer;

  localparam int PL  = 4;
  localparam int TMO = 16;
`ifdef NONCE_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef struct packed {
    logic found;
    logic exhausted;
    logic timed_out;
  } res_t;

  logic clk = 1'b0;
  logic reset;

  nonce_sequencer_if #(.NONCE_W(32)) bus ();

  nonce_sequencer #(
    .NONCE_W    (32),
    .PIPE_LAT   (PL),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_nonce[$];
  res_t        exp_res[$];
  res_t        last_res;

  logic        armed = 1'b0;
  logic [31:0] target = '0;
  logic        spur = 1'b0;
  logic        valid_r = 1'b0;
  logic        prev_fin = 1'b1;
  logic        h_vld[0:PL];
  logic [31:0] h_n[0:PL];

  assign bus.valid_in = valid_r | spur;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pops and the hash-core delay line, both on the falling edge.
  initial begin
    for (int i = 0; i <= PL; i++) begin
      h_vld[i] = 1'b0;
      h_n[i]   = '0;
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.nonce_vld) begin
        if (exp_nonce.size() == 0) chk("nonce_extra", {32'h0, bus.nonce_1}, 64'hdead_0000_0000);
        else                       chk("nonce", {32'h0, bus.nonce_1}, {32'h0, exp_nonce.pop_front()});
      end
      if (bus.fin && !prev_fin) begin
        if (exp_res.size() == 0) begin
          chk("result_extra", 64'd1, 64'd0);
        end else begin
          res_t r;
          r = exp_res.pop_front();
          chk("found", {63'h0, bus.found}, {63'h0, r.found});
          chk("exhausted", {63'h0, bus.exhausted}, {63'h0, r.exhausted});
          chk("timed_out", {63'h0, bus.timed_out}, {63'h0, r.timed_out});
        end
      end
      chk("busy_vs_fin", {63'h0, bus.busy}, {63'h0, !bus.fin});
    end
    prev_fin = bus.fin;
    for (int i = PL; i > 0; i--) begin
      h_vld[i] = h_vld[i-1];
      h_n[i]   = h_n[i-1];
    end
    h_vld[0] = bus.nonce_vld;
    h_n[0]   = bus.nonce_1;
    valid_r  = armed && h_vld[PL] && (h_n[PL] == target);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] l);
    bus.start       = 1'b1;
    bus.nonce_start = s;
    bus.nonce_limit = l;
    cyc(1);
    bus.start = 1'b0;
  endtask

  // Reference: issue count is the range length (capped by the budget), cut short
  // PIPE_LAT cycles after the target nonce if it is among those issued.
  task automatic run_search(input logic [31:0] s, input logic [31:0] l,
                            input bit tgt_en, input longint unsigned idx);
    logic [31:0]     diff;
    longint unsigned len, n, issued;
    bit              hit, tmo;
    res_t            r;
    bit              done;
    diff   = l - s;
    len    = longint'(diff) + 1;
    tmo    = TMO_EN && (len > TMO);
    n      = tmo ? TMO : len;
    hit    = tgt_en && (idx < n);
    issued = hit ? (((idx + PL + 1) < n) ? (idx + PL + 1) : n) : n;
    for (longint unsigned i = 0; i < issued; i++) exp_nonce.push_back(s + 32'(i));
    r.found     = hit;
    r.exhausted = !hit && !tmo;
    r.timed_out = !hit && tmo;
    exp_res.push_back(r);
    last_res = r;
    armed  = tgt_en;
    target = s + 32'(idx);
    pulse_start(s, l);
    @(negedge clk);
    chk("launch_fin", {63'h0, bus.fin}, 64'd0);
    chk("launch_clear", {61'h0, bus.found, bus.exhausted, bus.timed_out}, 64'd0);
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (bus.fin) done = 1'b1;
    end
    if (!done) chk("search_timeout", 64'd0, 64'd1);
    armed = 1'b0;
    cyc(PL + 3);
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.nonce_start = '0;
    bus.nonce_limit = '0;
    reset           = 1'b1;
    cyc(3);
    @(negedge clk);
    chk("rst_nonce_1", {32'h0, bus.nonce_1}, 64'd0);
    chk("rst_nonce_vld", {63'h0, bus.nonce_vld}, 64'd0);
    chk("rst_fin", {63'h0, bus.fin}, 64'd1);
    chk("rst_busy", {63'h0, bus.busy}, 64'd0);
    chk("rst_flags", {61'h0, bus.found, bus.exhausted, bus.timed_out}, 64'd0);
    cyc(1);
    reset = 1'b0;
    cyc(2);

    // Directed scenarios
    run_search(32'h10, 32'h1F, 1'b0, 0);
    run_search(32'h10, 32'h1F, 1'b1, 3);
    run_search(32'hFFFF_FFFE, 32'h1, 1'b0, 0);
    run_search(32'h55, 32'h55, 1'b1, 0);

    // valid_in while DONE must not disturb the held flags
    spur = 1'b1;
    cyc(1);
    spur = 1'b0;
    @(negedge clk);
    chk("spur_fin", {63'h0, bus.fin}, 64'd1);
    chk("spur_flags", {61'h0, bus.found, bus.exhausted, bus.timed_out},
        {61'h0, last_res.found, last_res.exhausted, last_res.timed_out});
    cyc(1);

    if (TMO_EN) run_search(32'h0, 32'hFFFF, 1'b0, 0);
    else        run_search(32'h0, 32'h3F, 1'b0, 0);

    // Ignored mid-run start, then reset mid-run
    for (int i = 0; i < 30; i++) exp_nonce.push_back(32'h200 + 32'(i));
    pulse_start(32'h200, 32'h21D);
    cyc(2);
    pulse_start(32'hABC, 32'hABD);
    cyc(2);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_nonce_1", {32'h0, bus.nonce_1}, 64'd0);
    chk("midrst_vld", {63'h0, bus.nonce_vld}, 64'd0);
    chk("midrst_fin", {63'h0, bus.fin}, 64'd1);
    chk("midrst_busy", {63'h0, bus.busy}, 64'd0);
    chk("midrst_flags", {61'h0, bus.found, bus.exhausted, bus.timed_out}, 64'd0);
    exp_nonce.delete();
    cyc(1);
    reset = 1'b0;
    cyc(3);
    chk("post_rst_idle_vld", {63'h0, bus.nonce_vld}, 64'd0);

    // Randomized searches, some straddling the wrap point
    for (int k = 0; k < 12; k++) begin
      logic [31:0] s;
      int unsigned len, idx;
      bit          te;
      s   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 20))) : $urandom;
      len = $urandom_range(1, 40);
      idx = $urandom_range(0, len + 2);
      te  = ($urandom_range(0, 2) != 0);
      run_search(s, s + 32'(len) - 32'd1, te, longint'(idx));
    end

    chk("nonce_queue_empty", 64'(exp_nonce.size()), 64'd0);
    chk("result_queue_empty", 64'(exp_res.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
